sd_block_receiver: RTL

Byte-level receive stage that sits directly downstream of the 8-bit data deserializer in the SD card SPI reader. Each read operation:
- hunts for the single-block start token (0xFE);
- captures exactly BLOCK_BYTES payload bytes into an internal FIFO;
- consumes the two trailing CRC bytes;
- reports completion or error.

Downstream logic pops payload bytes from the FIFO at its own pace. The reader FSM pulses `block_start` after the read command's R1 response.

---
 rtl/sd_pkg.sv | 32 +++
 rtl/sd_byte_fifo.sv | 86 ++++++++
 rtl/sd_block_receiver.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared constants for the SD card SPI block reader: tokens, FSM encoding,
// err_code bit positions and the CRC-16/XMODEM byte-update helper.
package sd_pkg;

   localparam logic [7:0]  SD_START_TOKEN = 8'hFE;
   localparam logic [7:0]  SD_IDLE_BYTE   = 8'hFF;
   localparam logic [15:0] SD_CRC16_POLY  = 16'h1021;

   typedef logic [2:0] sd_state_t;

   localparam sd_state_t ST_IDLE   = 3'd0;
   localparam sd_state_t ST_HUNT   = 3'd1;
   localparam sd_state_t ST_DATA   = 3'd2;
   localparam sd_state_t ST_CRC_HI = 3'd3;
   localparam sd_state_t ST_CRC_LO = 3'd4;
   localparam sd_state_t ST_DONE   = 3'd5;

   localparam int ERR_TOKEN_BIT = 0;
   localparam int ERR_OVFL_BIT  = 1;
   localparam int ERR_CRC_BIT   = 2;

   // MSB-first CRC-16 update over one byte.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
      logic [15:0] c;
      c = crc_in ^ {data, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ SD_CRC16_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/sd_byte_fifo.sv
// Synchronous byte FIFO with show-ahead output; the head is held in a
// registered read stage fed by the next read pointer, with write bypass.
module sd_byte_fifo
   import sd_pkg::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    push,
   input  logic                    pop,
   input  logic [7:0]              din,
   output logic [7:0]              dout,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic [7:0]    dout_q;
   logic          do_push, do_pop, head_load;

   assign empty = (level_q == '0);
   assign full  = (level_q == (AW+1)'(DEPTH));

   // A pop alongside a push is honoured even at the empty/full boundaries.
   assign do_push   = push && (!full || pop);
   assign do_pop    = pop && (!empty || push);
   assign head_load = do_pop || (do_push && empty);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
         level_d = level_q + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
         level_d = level_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         dout_q <= 8'h00;
      end else if (head_load) begin
         if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            dout_q <= din;
         end else begin
            dout_q <= mem_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   assign dout  = dout_q;
   assign level = level_q;

endmodule

// File: rtl/sd_block_receiver.sv
// SD single-block receive stage: token hunt, payload capture into a FIFO, CRC
// consumption. Optional CRC-16 payload check enabled by SD_BLOCK_CRC16_CHECK_EN.
module sd_block_receiver
   import sd_pkg::*;
#(
   parameter int BLOCK_BYTES   = 512,
   parameter int FIFO_DEPTH    = 1024,
   parameter int TOKEN_TIMEOUT = 255
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         block_start,
   input  logic [7:0]                   byte_in,
   input  logic                         byte_valid,
   input  logic                         pop,
   output logic [7:0]                   data_out,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(FIFO_DEPTH):0]  fill_level,
   output logic                         busy,
   output logic                         block_done,
   output logic                         block_error,
   output logic [2:0]                   err_code
);

   localparam int BW = $clog2(BLOCK_BYTES + 1);
   localparam int HW = $clog2(TOKEN_TIMEOUT + 1);
   localparam logic [BW-1:0] BYTE_LAST  = BW'(BLOCK_BYTES - 1);
   localparam logic [HW-1:0] HUNT_LIMIT = HW'(TOKEN_TIMEOUT);

   sd_state_t     state_q, state_d;
   logic [BW-1:0] byte_cnt_q, byte_cnt_d;
   logic [HW-1:0] hunt_cnt_q, hunt_cnt_d;
   logic [2:0]    err_q, err_d;
   logic          blk_err_q, blk_err_d;
   logic          done_q, done_d;
   logic          fifo_push, finish, crc_bad;

   sd_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (fifo_push),
      .pop   (pop),
      .din   (byte_in),
      .dout  (data_out),
      .empty (empty),
      .full  (full),
      .level (fill_level)
   );

`ifdef SD_BLOCK_CRC16_CHECK_EN
   logic [15:0] crc_q, crc_d;
   logic [7:0]  crc_hi_q, crc_hi_d;

   always_comb begin
      crc_d    = crc_q;
      crc_hi_d = crc_hi_q;
      if (block_start) begin
         crc_d = '0;
      end else if (byte_valid) begin
         if (state_q == ST_DATA) begin
            crc_d = crc16_byte(crc_q, byte_in);
         end
         if (state_q == ST_CRC_HI) begin
            crc_hi_d = byte_in;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         crc_q    <= '0;
         crc_hi_q <= '0;
      end else begin
         crc_q    <= crc_d;
         crc_hi_q <= crc_hi_d;
      end
   end

   assign crc_bad = ({crc_hi_q, byte_in} != crc_q);
`else
   assign crc_bad = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      hunt_cnt_d = hunt_cnt_q;
      err_d      = err_q;
      blk_err_d  = blk_err_q;
      done_d     = 1'b0;
      fifo_push  = 1'b0;
      finish     = 1'b0;
      // A new arm request overrides whatever byte arrives in the same cycle.
      if (block_start) begin
         state_d    = ST_HUNT;
         byte_cnt_d = '0;
         hunt_cnt_d = '0;
         err_d      = '0;
         blk_err_d  = 1'b0;
      end else if (byte_valid) begin
         case (state_q)
            ST_HUNT: begin
               if (byte_in == SD_START_TOKEN) begin
                  state_d = ST_DATA;
               end else if ((byte_in[7:4] == 4'h0) && (byte_in[3:0] != 4'h0)) begin
                  err_d[ERR_TOKEN_BIT] = 1'b1;
                  finish               = 1'b1;
               end else begin
                  hunt_cnt_d = hunt_cnt_q + HW'(1);
                  if (hunt_cnt_d == HUNT_LIMIT) begin
                     err_d[ERR_TOKEN_BIT] = 1'b1;
                     finish               = 1'b1;
                  end
               end
            end
            ST_DATA: begin
               fifo_push  = 1'b1;
               if (full && !pop) begin
                  err_d[ERR_OVFL_BIT] = 1'b1;
               end
               byte_cnt_d = byte_cnt_q + BW'(1);
               if (byte_cnt_q == BYTE_LAST) begin
                  state_d = ST_CRC_HI;
               end
            end
            ST_CRC_HI: begin
               state_d = ST_CRC_LO;
            end
            ST_CRC_LO: begin
               if (crc_bad) begin
                  err_d[ERR_CRC_BIT] = 1'b1;
               end
               finish = 1'b1;
            end
            default: begin
            end
         endcase
         if (finish) begin
            state_d   = ST_DONE;
            blk_err_d = |err_d;
            done_d    = (err_d == 3'b000);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         byte_cnt_q <= '0;
         hunt_cnt_q <= '0;
         err_q      <= '0;
         blk_err_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         hunt_cnt_q <= hunt_cnt_d;
         err_q      <= err_d;
         blk_err_q  <= blk_err_d;
         done_q     <= done_d;
      end
   end

   assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign block_done  = done_q;
   assign block_error = blk_err_q;
   assign err_code    = err_q;

endmodule
